mem_port_responder: RTL
=======================

# mem_port_responder

Memory-side responder for the processor's instruction-fetch and data-access requests. Holds a single-ported array of 16-bit words, arbitrates one fetch and one data port onto it, and returns read data or write acknowledgements after a fixed pipelined latency. Sits between the processor core and the backing storage, replacing the zero-latency memory model.

## Interface

- AW, 10, word-address width; array holds 2^AW words of 16 bits
- LAT, 2, response latency in cycles, legal range 1..4

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- f_req  in  1  fetch request
- f_addr  in  16  fetch byte address; bit 0 ignored, word index = f_addr[AW:1]
- f_ready  out  1  fetch grant (combinational); accept = f_req & f_ready
- f_valid  out  1  fetch response valid, one-cycle pulse
- f_data  out  16  fetch read data, meaningful only while f_valid
- d_req  in  1  data request
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  16  data byte address; bit 0 ignored
- d_wdata  in  16  store data
- d_ready  out  1  data grant (combinational); accept = d_req & d_ready
- d_valid  out  1  data response valid, one-cycle pulse (load data or store ack)
- d_rdata  out  16  load data; on store ack, echo of stored word
- busy  out  1  any response in flight

## Operation

- One array access per cycle.
- Only one request: granted if present.
- Both requests, same cycle: conflict resolved by 1-bit priority pointer `pri` (0 = data first, 1 = fetch first). Loser is stalled (ready=0) and must hold request stable. After each conflict, `pri` flips to favour the loser.
- Non-conflict cycles leave `pri` unchanged.
- Store: array written at the accept edge. Response carries the written word.
- Load/fetch: array word read at the accept edge, entered into the response pipeline.
- Response pipeline: LAT stages, each {valid, port, data}. Responses retire in acceptance order. Stage LAT drives f_valid/f_data or d_valid/d_rdata by its port bit.
- Output data fields are 0 whenever the corresponding valid is 0.
- Address bits above AW are ignored (wrap modulo 2^AW words).
- Read-after-write: a load accepted any cycle after a store to the same word returns the new value. Same-cycle collision is impossible (single grant).
- busy = OR of all stage valids.

## Timing

- Reset (async assert): all stage valids 0, all data 0, `pri` = 0, f_valid = d_valid = 0, busy = 0.
- Array contents are not reset. Stores already committed survive reset.
- Reset mid-operation discards in-flight responses; no valid pulse for them after deassert.
- Latency: request accepted at edge N, so response valid is high from edge N+LAT-1 through edge N+LAT.
- Exactly one response per accepted request. With LAT=1 the response is visible in the cycle after acceptance.
- Back-to-back accepts every cycle: one response every cycle, no bubbles.
- Ready depends only on f_req, d_req and `pri` (no dependence on pipeline state; the pipeline never backpressures).

## Configuration

- MEM_TRACE_EN defined: on every accept edge, `$write` one line: "mem F|DR|DW addr=%h data=%h". Data is the read word or the stored word.
- MEM_TRACE_EN undefined: no simulation output. Logic is identical.

## Test plan

- Reset then idle: rst=1 for 2 cycles then 0, no requests -> f_valid=d_valid=busy=0, f_data=d_rdata=0 for 10 cycles.
- Store/load, LAT=2: store 16'hBEEF at d_addr 16'h0010 (edge N) -> d_valid pulse after edge N+1 with d_rdata=16'hBEEF. Load 16'h0011 at edge N+1 -> d_rdata=16'hBEEF after edge N+2 (bit 0 ignored).
- Conflict alternation: f_req and d_req held high 4 cycles, distinct addresses -> grants go D, F, D, F. `pri` = 0 afterwards.
- Streaming fetch, LAT=3: fetch 16'h0000, 0002, 0004, 0006 on consecutive edges, words preloaded 1..4 -> f_valid high 4 consecutive cycles, f_data 1,2,3,4 in order. busy falls 1 cycle after the last valid.
- Wrap, AW=10: store 16'h1234 at 16'h0004, load 16'h0804 -> d_rdata=16'h1234.
- Reset mid-flight, LAT=4: accept load, assert rst 2 cycles later -> no d_valid ever. A prior store is still readable after reset.

Source files
------------

// File: rtl/mem_port_responder.sv
// rtl/mem_port_responder.sv - fetch/data port arbiter over a 16-bit word array with LAT-stage response pipeline
// Optional MEM_TRACE_EN: prints one line per accepted request; logic is unchanged.
module mem_port_responder #(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ready,
  output logic        f_valid,
  output logic [15:0] f_data,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        busy
);

  localparam int DEPTH = 1 << AW;

  logic [15:0]   mem [0:DEPTH-1];

  logic          pri;
  logic          pri_next;
  logic          conflict;
  logic          grant_f;
  logic          grant_d;
  logic          accept;
  logic          acc_store;
  logic [AW-1:0] f_idx;
  logic [AW-1:0] d_idx;
  logic [AW-1:0] acc_idx;
  logic [15:0]   acc_data;

  logic [LAT-1:0] st_valid;
  logic [LAT-1:0] st_port;
  logic [15:0]    st_data [0:LAT-1];

  // Byte bit 0 and bits above the word index are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr, d_addr};

  assign f_idx = f_addr[AW:1];
  assign d_idx = d_addr[AW:1];

  // Grants are purely a function of the two requests and the priority bit.
  assign conflict = f_req & d_req;
  assign f_ready  = ~d_req | pri;
  assign d_ready  = ~f_req | ~pri;
  assign grant_f  = f_req & f_ready;
  assign grant_d  = d_req & d_ready;
  assign accept   = grant_f | grant_d;

  assign acc_store = grant_d & d_wen;
  assign acc_idx   = grant_d ? d_idx : f_idx;
  assign acc_data  = acc_store ? d_wdata : mem[acc_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri <= 1'b0;
    end else begin
      pri <= pri_next;
    end
  end

  always_comb begin
    pri_next = pri;
    if (conflict) begin
      pri_next = ~pri;
    end
  end

  // Array contents survive reset, so it lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (acc_store) begin
      mem[d_idx] <= d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= '0;
      st_port  <= '0;
      for (int i = 0; i < LAT; i++) begin
        st_data[i] <= '0;
      end
    end else begin
      st_valid[0] <= accept;
      st_port[0]  <= grant_d;
      st_data[0]  <= accept ? acc_data : 16'h0000;
      for (int i = 1; i < LAT; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_port[i]  <= st_port[i-1];
        st_data[i]  <= st_data[i-1];
      end
    end
  end

  always_comb begin
    f_valid = 1'b0;
    f_data  = 16'h0000;
    d_valid = 1'b0;
    d_rdata = 16'h0000;
    if (st_valid[LAT-1]) begin
      if (st_port[LAT-1]) begin
        d_valid = 1'b1;
        d_rdata = st_data[LAT-1];
      end else begin
        f_valid = 1'b1;
        f_data  = st_data[LAT-1];
      end
    end
    busy = |st_valid;
  end

`ifdef MEM_TRACE_EN
  always @(posedge clk) begin
    if (!rst && accept) begin
      if (grant_f) begin
        $write("mem F addr=%h data=%h\n", f_addr, acc_data);
      end else if (d_wen) begin
        $write("mem DW addr=%h data=%h\n", d_addr, acc_data);
      end else begin
        $write("mem DR addr=%h data=%h\n", d_addr, acc_data);
      end
    end
  end
`else
`endif

endmodule
